// File: rtl/cpu_pkg.sv
// Shared types for the MiniMicro execute/control core: instruction layout,
// opcodes, FSM states and status-flag bit positions.
package cpu_pkg;

  localparam int unsigned InstrW     = 28;
  localparam int unsigned Src2ImmBit = 8;

  // Architectural flag vector is {N, Z, C, V}
  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  typedef enum logic [4:0] {
    OpAnds  = 5'd1,
    OpOrs   = 5'd2,
    OpXors  = 5'd3,
    OpNots  = 5'd4,
    OpAdds  = 5'd5,
    OpSubs  = 5'd6,
    OpAdcs  = 5'd7,
    OpSbcs  = 5'd8,
    OpMuls  = 5'd9,
    OpLsls  = 5'd10,
    OpLsrs  = 5'd11,
    OpAsrs  = 5'd12,
    OpRors  = 5'd13,
    OpIncs  = 5'd14,
    OpDecs  = 5'd15,
    OpNegs  = 5'd16,
    OpRsbs  = 5'd17,
    OpCmp   = 5'd18,
    OpNop   = 5'd19,
    OpLoadi = 5'd20,
    OpStore = 5'd21,
    OpMov   = 5'd22,
    OpJ     = 5'd23,
    OpBeq   = 5'd24,
    OpHlt   = 5'd25
  } opcode_e;

  typedef struct packed {
    logic [4:0] opcode;
    logic [8:0] dst;
    logic [4:0] src1;
    logic [8:0] src2;
  } instr_t;

  typedef enum logic [2:0] {
    StFetch,
    StExec,
    StAluWait,
    StMemWait,
    StHalt
  } cpu_state_e;

  // Opcodes 1..18 are issued to the ALU (CMP included, it only skips writeback)
  function automatic logic is_alu_op(logic [4:0] op);
    return (op >= OpAnds) && (op <= OpCmp);
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// asynchronous active-low clear of every entry.
module cpu_regfile #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned REG_IDX_W = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [REG_IDX_W-1:0] raddr_a,
  output logic [DATA_W-1:0]    rdata_a,
  input  logic [REG_IDX_W-1:0] raddr_b,
  output logic [DATA_W-1:0]    rdata_b
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/cpu_core_ctrl.sv
// Multi-cycle execute/control core: fetch handshake, decode, ALU issue,
// data-memory transactions, PC sequencing and architectural flags.
module cpu_core_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned PC_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   pc,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [InstrW-1:0] instr,
  output logic              alu_en,
  output logic [4:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              mem_req,
  output logic              mem_we,
  output logic [8:0]        mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [3:0]        flags,
  output logic              retired,
  output logic              halted,
  output logic              illegal_op
);

  localparam int unsigned     REG_IDX_W = $clog2(NUM_REGS);
  localparam logic [PC_W-1:0] PcOne     = PC_W'(1);

  cpu_state_e state_q;
  instr_t     instr_q;
  instr_t     dec;

  logic                 accept;
  logic [DATA_W-1:0]    rdata_a;
  logic [DATA_W-1:0]    rdata_b;
  logic [DATA_W-1:0]    op2;
  logic                 rf_we;
  logic [DATA_W-1:0]    rf_wdata;
  logic [REG_IDX_W-1:0] rf_waddr;
  logic                 unused_bits;

  assign instr_ready = (state_q == StFetch);
  assign accept      = instr_valid & instr_ready;

  // Operands come from the incoming word while fetching (ALU is issued on accept)
  // and from the latched word afterwards.
  assign dec = (state_q == StFetch) ? instr_t'(instr) : instr_q;
  assign op2 = dec.src2[Src2ImmBit] ? DATA_W'(dec.src2[7:0]) : rdata_b;

  assign rf_waddr    = instr_q.dst[REG_IDX_W-1:0];
  assign unused_bits = ^{dec.dst, dec.src1, dec.src2};

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = rdata_a;
    case (state_q)
      StExec:    rf_we = (instr_q.opcode == OpMov);
      StAluWait: begin
        rf_we    = (instr_q.opcode != OpCmp);
        rf_wdata = alu_result;
      end
      StMemWait: begin
        rf_we    = mem_req & mem_ack & ~mem_we;
        rf_wdata = mem_rdata;
      end
      default: ;
    endcase
  end

  cpu_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .REG_IDX_W(REG_IDX_W)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr_a(dec.src1[REG_IDX_W-1:0]),
    .rdata_a(rdata_a),
    .raddr_b(dec.src2[REG_IDX_W-1:0]),
    .rdata_b(rdata_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StFetch;
      instr_q    <= '0;
      pc         <= '0;
      alu_en     <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      flags      <= '0;
      retired    <= 1'b0;
      halted     <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      alu_en  <= 1'b0;
      retired <= 1'b0;
      case (state_q)
        StFetch: begin
          if (accept) begin
            instr_q <= dec;
            state_q <= StExec;
            // Issue now so the registered ALU result is ready in ALU_WAIT
            if (is_alu_op(dec.opcode)) begin
              alu_en <= 1'b1;
              alu_op <= dec.opcode;
              alu_a  <= rdata_a;
              alu_b  <= op2;
            end
          end
        end
        StExec: begin
          if (is_alu_op(instr_q.opcode)) begin
            state_q <= StAluWait;
          end else begin
            case (opcode_e'(instr_q.opcode))
              OpLoadi: begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= instr_q.src2;
                state_q  <= StMemWait;
              end
              OpStore: begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= instr_q.dst;
                mem_wdata <= rdata_a;
                state_q   <= StMemWait;
              end
              OpJ: begin
                pc      <= instr_q.dst[PC_W-1:0];
                retired <= 1'b1;
                state_q <= StFetch;
              end
              OpBeq: begin
                pc      <= (rdata_a == op2) ? instr_q.dst[PC_W-1:0] : pc + PcOne;
                retired <= 1'b1;
                state_q <= StFetch;
              end
              OpHlt: begin
                halted  <= 1'b1;
                state_q <= StHalt;
              end
              OpNop, OpMov: begin
                pc      <= pc + PcOne;
                retired <= 1'b1;
                state_q <= StFetch;
              end
              default: begin
                illegal_op <= 1'b1;
                pc         <= pc + PcOne;
                retired    <= 1'b1;
                state_q    <= StFetch;
              end
            endcase
          end
        end
        StAluWait: begin
          flags   <= {alu_flags[FlagN], alu_flags[FlagZ], alu_flags[FlagC], alu_flags[FlagV]};
          pc      <= pc + PcOne;
          retired <= 1'b1;
          state_q <= StFetch;
        end
        StMemWait: begin
          if (mem_req && mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            pc      <= pc + PcOne;
            retired <= 1'b1;
            state_q <= StFetch;
          end
        end
        StHalt: state_q <= StHalt;
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_ctrl.sv
// Directed bench for cpu_core_ctrl: a vector table of single instructions
// plus hand-written memory, illegal/halt and mid-transaction reset sequences.
module tb_cpu_core_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [27:0] instr;
  logic        alu_en;
  logic [4:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        mem_req;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [3:0]  flags;
  logic        retired;
  logic        halted;
  logic        illegal_op;

  always #5 clk = ~clk;

  cpu_core_ctrl #(
    .DATA_W  (32),
    .NUM_REGS(16),
    .PC_W    (9)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .alu_en     (alu_en),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .flags      (flags),
    .retired    (retired),
    .halted     (halted),
    .illegal_op (illegal_op)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Observations captured by run_instr
  int          t_cyc;
  int          t_alu_n;
  logic [31:0] t_alu_a;
  logic [31:0] t_alu_b;
  logic [4:0]  t_alu_op;
  int          t_req_n;
  logic [8:0]  t_addr;
  logic        t_addr_moved;
  logic        t_we;
  logic [31:0] t_wdata;
  int          t_ret_n;
  logic [8:0]  t_pc;
  logic [3:0]  t_flags;
  logic        t_rdy;

  typedef struct {
    logic [27:0] w;
    logic [31:0] res;
    logic [3:0]  fl;
    int          exp_cyc;
    logic        exp_alu;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [8:0]  exp_pc;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [27:0] mk(input int op, input int dst, input int s1, input int s2);
    return {op[4:0], dst[8:0], s1[4:0], s2[8:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one instruction from a negedge and watches until one cycle past
  // its retire pulse (or a 20-cycle bound). k counts clock edges after accept.
  task automatic run_instr(input logic [27:0] w, input logic [31:0] res, input logic [3:0] fl,
                           input int ack_delay, input logic [31:0] rdata, input logic early_ack);
    int alu_k;
    alu_k        = -10;
    t_cyc        = -1;
    t_alu_n      = 0;
    t_req_n      = 0;
    t_ret_n      = 0;
    t_addr_moved = 1'b0;
    instr_valid  = 1'b1;
    instr        = w;
    t_rdy        = instr_ready;
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      instr       = '0;
      mem_ack     = 1'b0;
      if (alu_en) begin
        t_alu_n++;
        t_alu_a  = alu_a;
        t_alu_b  = alu_b;
        t_alu_op = alu_op;
        alu_k    = k;
      end
      if (k == alu_k || k == alu_k + 1) begin
        alu_result = res;
        alu_flags  = fl;
      end else begin
        alu_result = 32'hBAD0_BAD0;
        alu_flags  = 4'hF;
      end
      if (k == 0 && early_ack && !mem_req) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_1111;
      end
      if (mem_req) begin
        t_req_n++;
        if (t_req_n == 1) begin
          t_addr  = mem_addr;
          t_we    = mem_we;
          t_wdata = mem_wdata;
        end else if (mem_addr !== t_addr || mem_wdata !== t_wdata || mem_we !== t_we) begin
          t_addr_moved = 1'b1;
        end
        if (t_req_n == ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end
      end
      if (retired) begin
        t_ret_n++;
        if (t_cyc < 0) begin
          t_cyc   = k;
          t_pc    = pc;
          t_flags = flags;
        end
      end
      if (t_cyc >= 0 && k == t_cyc + 1) break;
    end
  endtask

  initial begin
    rst         = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    alu_result  = '0;
    alu_flags   = '0;
    mem_rdata   = '0;
    mem_ack     = 1'b0;

    //                 word                       res            fl     cyc alu  a              b         pc      flags
    vecs[0]  = '{mk(22, 1, 0, 'h000),       32'h0,         4'h0, 1, 0, 32'h0,         32'h0,  9'd1,   4'h0};
    vecs[1]  = '{mk(5, 2, 1, 'h105),        32'h5,         4'h0, 2, 1, 32'h0,         32'h5,  9'd2,   4'h0};
    vecs[2]  = '{mk(5, 3, 2, 'h002),        32'hA,         4'h9, 2, 1, 32'h5,         32'h5,  9'd3,   4'h9};
    vecs[3]  = '{mk(18, 7, 3, 'h10A),       32'h0,         4'h4, 2, 1, 32'hA,         32'hA,  9'd4,   4'h4};
    vecs[4]  = '{mk(5, 8, 7, 'h100),        32'h77,        4'h0, 2, 1, 32'h0,         32'h0,  9'd5,   4'h0};
    vecs[5]  = '{mk(5, 9, 8, 'h002),        32'h12345678,  4'h3, 2, 1, 32'h77,        32'h5,  9'd6,   4'h3};
    vecs[6]  = '{mk(19, 0, 0, 'h000),       32'h0,         4'h0, 1, 0, 32'h0,         32'h0,  9'd7,   4'h3};
    vecs[7]  = '{mk(22, 10, 9, 'h000),      32'h0,         4'h0, 1, 0, 32'h0,         32'h0,  9'd8,   4'h3};
    vecs[8]  = '{mk(6, 11, 10, 'h002),      32'h12345673,  4'h0, 2, 1, 32'h12345678,  32'h5,  9'd9,   4'h0};
    vecs[9]  = '{mk(1, 12, 11, 'h1FF),      32'h73,        4'h8, 2, 1, 32'h12345673,  32'hFF, 9'd10,  4'h8};
    vecs[10] = '{mk(24, 'h1F0, 2, 'h105),   32'h0,         4'h0, 1, 0, 32'h0,         32'h0,  9'h1F0, 4'h8};
    vecs[11] = '{mk(24, 'h020, 2, 'h003),   32'h0,         4'h0, 1, 0, 32'h0,         32'h0,  9'h1F1, 4'h8};
    vecs[12] = '{mk(24, 'h0AA, 12, 'h173),  32'h0,         4'h0, 1, 0, 32'h0,         32'h0,  9'h0AA, 4'h8};
    vecs[13] = '{mk(23, 'h1FF, 0, 'h000),   32'h0,         4'h0, 1, 0, 32'h0,         32'h0,  9'h1FF, 4'h8};
    vecs[14] = '{mk(19, 0, 0, 'h000),       32'h0,         4'h0, 1, 0, 32'h0,         32'h0,  9'h000, 4'h8};
    // Register indices use only the low bits: src1=0x12 reads r2
    vecs[15] = '{mk(5, 'h10D, 'h12, 'h100), 32'h0,         4'h0, 2, 1, 32'h5,         32'h0,  9'h001, 4'h0};

    repeat (3) @(negedge clk);
    check("reset_pc", pc, 0);
    check("reset_ready", instr_ready, 1);
    check("reset_alu_en", alu_en, 0);
    check("reset_mem_req", mem_req, 0);
    check("reset_outs", {flags, retired, halted, illegal_op}, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      run_instr(vecs[i].w, vecs[i].res, vecs[i].fl, 0, 32'h0, 1'b0);
      check($sformatf("v%0d_ready", i), t_rdy, 1);
      check($sformatf("v%0d_cycle", i), t_cyc, vecs[i].exp_cyc);
      check($sformatf("v%0d_retire_cnt", i), t_ret_n, 1);
      check($sformatf("v%0d_alu_pulses", i), t_alu_n, vecs[i].exp_alu ? 1 : 0);
      if (vecs[i].exp_alu) begin
        check($sformatf("v%0d_alu_op", i), t_alu_op, vecs[i].w[27:23]);
        check($sformatf("v%0d_alu_a", i), t_alu_a, vecs[i].exp_a);
        check($sformatf("v%0d_alu_b", i), t_alu_b, vecs[i].exp_b);
      end
      check($sformatf("v%0d_pc", i), t_pc, vecs[i].exp_pc);
      check($sformatf("v%0d_flags", i), t_flags, vecs[i].exp_flags);
    end

    // LOADI r3 <- [0x40]: stray ack during EXEC, real ack on the third request cycle
    run_instr(mk(20, 3, 0, 'h040), 32'h0, 4'h0, 3, 32'hDEADBEEF, 1'b1);
    check("loadi_cycle", t_cyc, 4);
    check("loadi_req_cycles", t_req_n, 3);
    check("loadi_addr", t_addr, 9'h040);
    check("loadi_we", t_we, 0);
    check("loadi_stable", t_addr_moved, 0);
    check("loadi_retire_cnt", t_ret_n, 1);
    check("loadi_pc", t_pc, 9'd2);
    check("loadi_req_drop", mem_req, 0);

    // STORE r3 -> [0x155] shows the loaded value
    run_instr(mk(21, 'h155, 3, 'h000), 32'h0, 4'h0, 1, 32'h0, 1'b0);
    check("store_cycle", t_cyc, 2);
    check("store_we", t_we, 1);
    check("store_addr", t_addr, 9'h155);
    check("store_wdata", t_wdata, 32'hDEADBEEF);
    check("store_pc", t_pc, 9'd3);

    // Reserved opcodes behave as NOP and set the sticky flag
    check("illegal_before", illegal_op, 0);
    run_instr(mk(27, 1, 0, 'h000), 32'h0, 4'h0, 0, 32'h0, 1'b0);
    check("op27_cycle", t_cyc, 1);
    check("op27_illegal", illegal_op, 1);
    check("op27_pc", t_pc, 9'd4);
    check("op27_no_alu", t_alu_n, 0);
    run_instr(mk(0, 1, 0, 'h000), 32'h0, 4'h0, 0, 32'h0, 1'b0);
    check("op0_pc", t_pc, 9'd5);
    run_instr(mk(22, 4, 3, 'h000), 32'h0, 4'h0, 0, 32'h0, 1'b0);
    check("illegal_sticky", illegal_op, 1);
    check("mov_after_illegal_pc", t_pc, 9'd6);

    // HLT: no retire, core stays halted with a valid instruction waiting
    run_instr(mk(25, 0, 0, 'h000), 32'h0, 4'h0, 0, 32'h0, 1'b0);
    check("hlt_no_retire", t_ret_n, 0);
    check("hlt_halted", halted, 1);
    instr_valid = 1'b1;
    instr       = mk(19, 0, 0, 'h000);
    repeat (5) @(negedge clk);
    check("hlt_ready", instr_ready, 0);
    check("hlt_pc", pc, 9'd6);
    check("hlt_still", halted, 1);
    instr_valid = 1'b0;

    rst = 1'b0;
    #1;
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal_op, 0);
    check("rst_flags_pc", {flags, pc}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // r3 cleared by reset; r5 <- 0x55
    run_instr(mk(5, 5, 3, 'h155), 32'h55, 4'h2, 0, 32'h0, 1'b0);
    check("post_rst_alu_a", t_alu_a, 32'h0);
    check("post_rst_alu_b", t_alu_b, 32'h55);
    check("post_rst_pc", t_pc, 9'd1);

    // Reset in the middle of a memory wait
    instr_valid = 1'b1;
    instr       = mk(20, 6, 0, 'h0AB);
    @(posedge clk);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 6 && !seen; k++) begin
        @(negedge clk);
        instr_valid = 1'b0;
        if (mem_req) seen = 1'b1;
      end
      check("midrst_req_seen", seen, 1);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_req_drop", mem_req, 0);
    check("midrst_pc", pc, 0);
    check("midrst_ready", instr_ready, 1);
    check("midrst_retired", retired, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_instr(mk(21, 'h010, 5, 'h000), 32'h0, 4'h0, 1, 32'h0, 1'b0);
    check("midrst_r5_cleared", t_wdata, 32'h0);
    check("midrst_store_pc", t_pc, 9'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_core_ctrl.md
Name: cpu_core_ctrl

Overview:
- Parametrised multi-cycle execute/control core for the 28-bit MiniMicro instruction word: opcode[27:23], destination[22:14], source_1[13:9], source_2[8:0].
- Owns the program counter, an internal register file and the status flags.
- Takes instructions over a valid/ready fetch handshake.
- Drives the existing registered ALU and a req/ack data-memory port; sits between the fetch unit and ALU/RAM.

Parameters:
- DATA_W, 32, register/ALU/memory data width.
- NUM_REGS, 16, register-file depth (power of 2, ≤32); REG_IDX_W = log2(NUM_REGS).
- PC_W, 9, program counter width (≤9).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc  out  PC_W  address of the instruction being fetched/executed.
- instr_valid  in  1  fetch unit has an instruction.
- instr_ready  out  1  core accepts an instruction.
- instr  in  28  instruction word.
- alu_en  out  1  one-cycle ALU start pulse.
- alu_op  out  5  opcode forwarded to the ALU.
- alu_a  out  DATA_W  ALU operand 1.
- alu_b  out  DATA_W  ALU operand 2.
- alu_result  in  DATA_W  ALU result, valid the cycle after alu_en.
- alu_flags  in  4  N,Z,C,V, valid with alu_result.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = write (STORE).
- mem_addr  out  9  RAM address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  load data, valid with mem_ack.
- mem_ack  in  1  memory completion.
- flags  out  4  architectural N,Z,C,V.
- retired  out  1  one-cycle pulse per completed instruction.
- halted  out  1  core is in HALT.
- illegal_op  out  1  sticky: a reserved opcode was executed.

Behaviour:
- Reset (rst=0, async): state=FETCH; pc=0; all registers=0; flags=0.
  - All outputs 0 except instr_ready, which is combinational from state and reads 1.
  - Asserting rst mid-transaction drops mem_req/alu_en immediately; no writeback occurs.
- Decode:
  - rd = destination[REG_IDX_W-1:0]; ra = source_1[REG_IDX_W-1:0].
  - op2 = {0, source_2[7:0]} zero-extended immediate when source_2[8]=1, else reg[source_2[REG_IDX_W-1:0]].
- States: FETCH, EXEC, ALU_WAIT, MEM_WAIT, HALT.
- FETCH: instr_ready=1. When instr_valid & instr_ready, latch instr and go to EXEC. No other state asserts instr_ready.
- EXEC (1 cycle):
  - Opcodes 1–17: alu_en=1, alu_op=opcode, alu_a=reg[ra], alu_b=op2; go to ALU_WAIT.
  - 18 CMP: same ALU issue; flags-only (no register write).
  - 19 NOP: retire.
  - 20 LOADI: mem_req=1, mem_we=0, mem_addr=source_2; go to MEM_WAIT.
  - 21 STORE: mem_req=1, mem_we=1, mem_addr=destination, mem_wdata=reg[ra]; go to MEM_WAIT.
  - 22 MOV: reg[rd] <= reg[ra]; retire.
  - 23 J: pc <= destination[PC_W-1:0]; retire.
  - 24 BEQ: if reg[ra]==op2 then pc <= destination[PC_W-1:0], else pc+1; retire.
  - 25 HLT: go to HALT, no retire pulse.
  - 0 and 26–31: set illegal_op (sticky until reset), then execute as NOP.
- ALU_WAIT (1 cycle):
  - Write alu_result to reg[rd], except CMP.
  - flags <= alu_flags for all of opcodes 1–18.
  - Retire.
- MEM_WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack.
  - On mem_ack: LOADI writes mem_rdata to reg[rd]; retire.
  - mem_ack while mem_req=0 is ignored.
- Retire: retired=1 for one cycle; pc <= pc+1 (mod 2^PC_W) unless J/BEQ-taken loaded it; state <= FETCH.
- HALT: halted=1; instr_ready=0; only reset exits.
- Minimum latencies (instruction accepted at cycle 0): retire at cycle 1 for MOV/J/BEQ/NOP; cycle 2 for ALU ops; cycle 2 + ack wait for memory ops.
- Register write and operand read of the same register never overlap, since reads occur only in EXEC.

Decomposition:
- Package cpu_pkg:
  - opcode enum (ANDS=1 … HLT=25);
  - instruction field struct / bit-slice constants;
  - state enum;
  - flag bit indices.
- Sub-module cpu_regfile (NUM_REGS×DATA_W, two async read ports, one sync write, async active-low clear).

Test Plan:
- Reset, then MOV r1←r0 with instr_valid=1 -> instr_ready=1 in FETCH; retired at cycle 1; pc=1; r1=0.
- ADDS r2 = r1 + imm (source_2=0x105) with alu_result=5, flags=0 -> alu_en pulse, alu_b=5, r2=5, retired at cycle 2, pc increments.
- LOADI r3 from addr 0x40 with mem_ack delayed 3 cycles, rdata=0xDEADBEEF -> mem_req held for 3 cycles with stable addr; r3=0xDEADBEEF at ack; single retire pulse.
- BEQ with equal operands, destination=0x1F0 (PC_W=9) -> pc=0x1F0. With unequal operands -> pc+1. J from pc=0x1FF via NOP -> pc wraps to 0.
- Opcode 27 -> illegal_op=1 and stays 1, behaves as NOP; then HLT -> halted=1, instr_ready=0 indefinitely.
- rst pulsed low during MEM_WAIT -> mem_req=0 immediately, pc=0, registers cleared, FETCH on release.
